// File: rtl/axi4_lite_reg_slave_if.sv
// +--------------------------------------------------------------------+
// | axi4_lite_reg_slave_if                                             |
// | AXI4-Lite bus bundle with master and slave views.                  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface axi4_lite_reg_slave_if #(
   parameter int DATA_BYTES = 4,
   parameter int ADDR_BYTES = 1
) ();
   logic                      awvalid;
   logic                      awready;
   logic [ADDR_BYTES*8-1:0]   awaddr;
   logic [2:0]                awprot;
   logic                      wvalid;
   logic                      wready;
   logic [DATA_BYTES*8-1:0]   wdata;
   logic [DATA_BYTES-1:0]     wstrb;
   logic                      bvalid;
   logic                      bready;
   logic [1:0]                bresp;
   logic                      arvalid;
   logic                      arready;
   logic [ADDR_BYTES*8-1:0]   araddr;
   logic [2:0]                arprot;
   logic                      rvalid;
   logic                      rready;
   logic [DATA_BYTES*8-1:0]   rdata;
   logic [1:0]                rresp;

   modport master (
      output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
             arvalid, araddr, arprot, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slave (
      input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
             arvalid, araddr, arprot, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

`default_nettype wire

// File: rtl/axi4_lite_reg_slave.sv
// +--------------------------------------------------------------------+
// | axi4_lite_reg_slave                                                |
// | AXI4-Lite register bank with byte strobes and flat register export.|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module axi4_lite_reg_slave #(
   parameter int DATA_BYTES = 4,
   parameter int ADDR_BYTES = 1,
   parameter int NUM_REGS   = 16
) (
   input  wire logic                                aclk,
   input  wire logic                                areset,
   axi4_lite_reg_slave_if.slave                     s_axi,
   output logic [NUM_REGS*DATA_BYTES*8-1:0]         regs_out,
   output logic [NUM_REGS-1:0]                      wr_pulse
);

   localparam int c_DW  = DATA_BYTES * 8;
   localparam int c_AW  = ADDR_BYTES * 8;
   localparam int c_LSB = $clog2(DATA_BYTES);
   localparam int c_IW  = c_AW - c_LSB;
   localparam logic [c_IW-1:0] c_LAST   = c_IW'(NUM_REGS - 1);
   localparam logic [1:0]      c_OKAY   = 2'b00;
   localparam logic [1:0]      c_SLVERR = 2'b10;

   localparam logic [0:0] c_W_IDLE = 1'b0;
   localparam logic [0:0] c_W_RESP = 1'b1;
   localparam logic [0:0] c_R_IDLE = 1'b0;
   localparam logic [0:0] c_R_DATA = 1'b1;

   logic [0:0]              r_wstate, w_wnext;
   logic [0:0]              r_rstate, w_rnext;
   logic                    r_aw_hold, r_w_hold;
   logic [c_AW-1:0]         r_awaddr_h;
   logic [c_DW-1:0]         r_wdata_h;
   logic [DATA_BYTES-1:0]   r_wstrb_h;
   logic [1:0]              r_bresp;
   logic [c_DW-1:0]         r_rdata;
   logic [1:0]              r_rresp;
   logic [NUM_REGS-1:0]     r_wr_pulse;
   logic [c_DW-1:0]         r_regs [NUM_REGS];

   logic                    w_awready, w_wready, w_bvalid;
   logic                    w_arready, w_rvalid;
   logic                    w_aw_hs, w_w_hs, w_ar_hs;
   logic                    w_have_aw, w_have_w, w_commit;
   logic [c_AW-1:0]         w_waddr;
   logic [c_DW-1:0]         w_wdata;
   logic [DATA_BYTES-1:0]   w_wstrb;
   logic [c_IW-1:0]         w_widx, w_ridx;
   logic                    w_wok, w_rok;
   logic [c_DW-1:0]         w_rsel;
   logic                    w_unused_ok;

   // AW and W are captured independently; live beats bypass the hold registers.
   assign w_aw_hs   = s_axi.awvalid & w_awready;
   assign w_w_hs    = s_axi.wvalid  & w_wready;
   assign w_have_aw = r_aw_hold | w_aw_hs;
   assign w_have_w  = r_w_hold  | w_w_hs;
   assign w_commit  = (r_wstate == c_W_IDLE) & !areset & w_have_aw & w_have_w;
   assign w_waddr   = r_aw_hold ? r_awaddr_h : s_axi.awaddr;
   assign w_wdata   = r_w_hold  ? r_wdata_h  : s_axi.wdata;
   assign w_wstrb   = r_w_hold  ? r_wstrb_h  : s_axi.wstrb;
   assign w_widx    = w_waddr[c_AW-1:c_LSB];
   assign w_wok     = (w_widx <= c_LAST);

   assign w_ar_hs   = s_axi.arvalid & w_arready;
   assign w_ridx    = s_axi.araddr[c_AW-1:c_LSB];
   assign w_rok     = (w_ridx <= c_LAST);

   // ---------------- write FSM ----------------
   always_ff @(posedge aclk) begin
      if (areset) r_wstate <= c_W_IDLE;
      else        r_wstate <= w_wnext;
   end

   always_comb begin
      w_wnext = r_wstate;
      case (r_wstate)
         c_W_IDLE: if (w_commit)     w_wnext = c_W_RESP;
         c_W_RESP: if (s_axi.bready) w_wnext = c_W_IDLE;
         default:                    w_wnext = c_W_IDLE;
      endcase
   end

   always_comb begin
      w_awready = 1'b0;
      w_wready  = 1'b0;
      w_bvalid  = 1'b0;
      if (!areset) begin
         case (r_wstate)
            c_W_IDLE: begin
               w_awready = !r_aw_hold;
               w_wready  = !r_w_hold;
            end
            c_W_RESP: w_bvalid = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_aw_hold  <= 1'b0;
         r_w_hold   <= 1'b0;
         r_awaddr_h <= '0;
         r_wdata_h  <= '0;
         r_wstrb_h  <= '0;
         r_bresp    <= c_OKAY;
         r_wr_pulse <= '0;
      end else begin
         r_wr_pulse <= '0;
         if (w_commit) begin
            r_aw_hold <= 1'b0;
            r_w_hold  <= 1'b0;
            r_bresp   <= w_wok ? c_OKAY : c_SLVERR;
            for (int i = 0; i < NUM_REGS; i++) begin
               if (w_widx == c_IW'(i)) r_wr_pulse[i] <= 1'b1;
            end
         end else begin
            if (w_aw_hs) begin
               r_aw_hold  <= 1'b1;
               r_awaddr_h <= s_axi.awaddr;
            end
            if (w_w_hs) begin
               r_w_hold  <= 1'b1;
               r_wdata_h <= s_axi.wdata;
               r_wstrb_h <= s_axi.wstrb;
            end
         end
      end
   end

   // Out-of-range indices match no register, so such writes change nothing.
   always_ff @(posedge aclk) begin
      if (areset) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      end else if (w_commit) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (w_widx == c_IW'(i)) begin
               for (int k = 0; k < DATA_BYTES; k++) begin
                  if (w_wstrb[k]) r_regs[i][k*8 +: 8] <= w_wdata[k*8 +: 8];
               end
            end
         end
      end
   end

   // ---------------- read FSM ----------------
   always_ff @(posedge aclk) begin
      if (areset) r_rstate <= c_R_IDLE;
      else        r_rstate <= w_rnext;
   end

   always_comb begin
      w_rnext = r_rstate;
      case (r_rstate)
         c_R_IDLE: if (w_ar_hs)      w_rnext = c_R_DATA;
         c_R_DATA: if (s_axi.rready) w_rnext = c_R_IDLE;
         default:                    w_rnext = c_R_IDLE;
      endcase
   end

   always_comb begin
      w_arready = 1'b0;
      w_rvalid  = 1'b0;
      if (!areset) begin
         case (r_rstate)
            c_R_IDLE: w_arready = 1'b1;
            c_R_DATA: w_rvalid  = 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      w_rsel = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (w_ridx == c_IW'(i)) w_rsel = r_regs[i];
      end
   end

   // Sampling the pre-edge array gives read-before-write on a same-edge collision.
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_rdata <= '0;
         r_rresp <= c_OKAY;
      end else if (w_ar_hs) begin
         r_rdata <= w_rsel;
         r_rresp <= w_rok ? c_OKAY : c_SLVERR;
      end
   end

   // ---------------- outputs ----------------
   assign s_axi.awready = w_awready;
   assign s_axi.wready  = w_wready;
   assign s_axi.bvalid  = w_bvalid;
   assign s_axi.bresp   = r_bresp;
   assign s_axi.arready = w_arready;
   assign s_axi.rvalid  = w_rvalid;
   assign s_axi.rdata   = r_rdata;
   assign s_axi.rresp   = r_rresp;
   assign wr_pulse      = r_wr_pulse;

   generate
      for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
         assign regs_out[g*c_DW +: c_DW] = r_regs[g];
      end
   endgenerate

   assign w_unused_ok = ^{s_axi.awprot, s_axi.arprot, r_awaddr_h, s_axi.awaddr, s_axi.araddr};

endmodule

`default_nettype wire

// File: tb/tb_axi4_lite_reg_slave.sv
// +--------------------------------------------------------------------+
// | tb_axi4_lite_reg_slave                                             |
// | Vector table, corner-case sequences and random traffic vs a model. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_axi4_lite_reg_slave;

   logic         aclk;
   logic         areset;
   logic [511:0] regs_out;
   logic [15:0]  wr_pulse;

   axi4_lite_reg_slave_if #(.DATA_BYTES(4), .ADDR_BYTES(1)) bus ();

   axi4_lite_reg_slave #(.DATA_BYTES(4), .ADDR_BYTES(1), .NUM_REGS(16)) dut (
      .aclk     (aclk),
      .areset   (areset),
      .s_axi    (bus),
      .regs_out (regs_out),
      .wr_pulse (wr_pulse)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   // Reference: a plain array of 16 words addressed by byte address / 4.
   logic [31:0] model_mem [16];

   task automatic model_reset();
      for (int i = 0; i < 16; i++) model_mem[i] = '0;
   endtask

   function automatic logic [1:0] model_write(input logic [7:0] addr, input logic [31:0] data,
                                              input logic [3:0] strb);
      int idx;
      idx = int'(addr) / 4;
      if (idx >= 16) return 2'b10;
      for (int k = 0; k < 4; k++)
         if (strb[k]) model_mem[idx][8*k +: 8] = data[8*k +: 8];
      return 2'b00;
   endfunction

   function automatic logic [15:0] model_pulse(input logic [7:0] addr);
      int idx;
      idx = int'(addr) / 4;
      return (idx < 16) ? (16'h0001 << idx) : 16'h0000;
   endfunction

   function automatic logic [31:0] model_rdata(input logic [7:0] addr);
      int idx;
      idx = int'(addr) / 4;
      return (idx < 16) ? model_mem[idx] : 32'h0;
   endfunction

   function automatic logic [511:0] model_flat();
      logic [511:0] f;
      for (int i = 0; i < 16; i++) f[i*32 +: 32] = model_mem[i];
      return f;
   endfunction

   task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly,
                            input logic [1:0] exp_resp, input logic [15:0] exp_pulse);
      fork
         begin
            bit done = 1'b0;
            repeat (aw_dly) tick();
            bus.awvalid = 1'b1;
            bus.awaddr  = addr;
            bus.awprot  = 3'($urandom);
            for (int n = 0; n < 20 && !done; n++) begin
               done = bus.awready;
               tick();
            end
            bus.awvalid = 1'b0;
            check("aw_handshake", done, 1);
         end
         begin
            bit done = 1'b0;
            repeat (w_dly) tick();
            bus.wvalid = 1'b1;
            bus.wdata  = data;
            bus.wstrb  = strb;
            for (int n = 0; n < 20 && !done; n++) begin
               done = bus.wready;
               tick();
            end
            bus.wvalid = 1'b0;
            check("w_handshake", done, 1);
         end
      join
      check("bvalid_latency", bus.bvalid, 1);
      check("bresp", bus.bresp, exp_resp);
      check("wr_pulse", wr_pulse, exp_pulse);
      for (int s = 0; s < b_dly; s++) begin
         tick();
         check("bvalid_stall", bus.bvalid, 1);
         check("bresp_stall", bus.bresp, exp_resp);
         check("awready_stall", bus.awready, 0);
         check("wready_stall", bus.wready, 0);
         check("wr_pulse_stall", wr_pulse, 0);
      end
      bus.bready = 1'b1;
      tick();
      bus.bready = 1'b0;
      check("bvalid_clear", bus.bvalid, 0);
      check("wr_pulse_one_cycle", wr_pulse, 0);
   endtask

   task automatic axi_read(input logic [7:0] addr, input int ar_dly, input int r_dly,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp);
      bit done = 1'b0;
      repeat (ar_dly) tick();
      bus.arvalid = 1'b1;
      bus.araddr  = addr;
      bus.arprot  = 3'($urandom);
      for (int n = 0; n < 20 && !done; n++) begin
         done = bus.arready;
         tick();
      end
      bus.arvalid = 1'b0;
      check("ar_handshake", done, 1);
      check("rvalid_latency", bus.rvalid, 1);
      check("rdata", bus.rdata, exp_data);
      check("rresp", bus.rresp, exp_resp);
      for (int s = 0; s < r_dly; s++) begin
         tick();
         check("rvalid_stall", bus.rvalid, 1);
         check("rdata_stall", bus.rdata, exp_data);
         check("arready_stall", bus.arready, 0);
      end
      bus.rready = 1'b1;
      tick();
      bus.rready = 1'b0;
      check("rvalid_clear", bus.rvalid, 0);
   endtask

   typedef struct {
      bit          is_wr;
      logic [7:0]  addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [1:0]  resp;
      logic [31:0] exp;
      logic [15:0] pulse;
   } vec_t;

   vec_t tbl[$];

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  er;
      logic [7:0]  ra;
      logic [31:0] rd;
      logic [3:0]  rs;

      tbl.push_back('{1'b1, 8'h04, 32'hDEADBEEF, 4'hF, 2'b00, 32'hDEADBEEF, 16'h0002});
      tbl.push_back('{1'b0, 8'h04, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF, 16'h0000});
      tbl.push_back('{1'b1, 8'h08, 32'h11223344, 4'hF, 2'b00, 32'h11223344, 16'h0004});
      tbl.push_back('{1'b1, 8'h08, 32'hAABBCCDD, 4'h5, 2'b00, 32'h11BB33DD, 16'h0004});
      tbl.push_back('{1'b0, 8'h08, 32'h0,        4'h0, 2'b00, 32'h11BB33DD, 16'h0000});
      tbl.push_back('{1'b1, 8'hC4, 32'hDEADBEEF, 4'hF, 2'b10, 32'h0,        16'h0000});
      tbl.push_back('{1'b0, 8'hC4, 32'h0,        4'h0, 2'b10, 32'h0,        16'h0000});
      tbl.push_back('{1'b0, 8'h05, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF, 16'h0000});
      tbl.push_back('{1'b0, 8'h0B, 32'h0,        4'h0, 2'b00, 32'h11BB33DD, 16'h0000});
      tbl.push_back('{1'b1, 8'h3C, 32'hCAFEF00D, 4'hF, 2'b00, 32'hCAFEF00D, 16'h8000});
      tbl.push_back('{1'b0, 8'h3F, 32'h0,        4'h0, 2'b00, 32'hCAFEF00D, 16'h0000});
      tbl.push_back('{1'b1, 8'h40, 32'h01020304, 4'hF, 2'b10, 32'h0,        16'h0000});
      tbl.push_back('{1'b0, 8'h40, 32'h0,        4'h0, 2'b10, 32'h0,        16'h0000});
      tbl.push_back('{1'b1, 8'h0E, 32'h12345678, 4'h0, 2'b00, 32'h0,        16'h0008});
      tbl.push_back('{1'b0, 8'h0C, 32'h0,        4'h0, 2'b00, 32'h0,        16'h0000});
      tbl.push_back('{1'b1, 8'h0D, 32'h0000A500, 4'h2, 2'b00, 32'h0000A500, 16'h0008});
      tbl.push_back('{1'b0, 8'hFF, 32'h0,        4'h0, 2'b10, 32'h0,        16'h0000});

      bus.awvalid = 1'b1; bus.awaddr = 8'h04; bus.awprot = 3'h0;
      bus.wvalid  = 1'b1; bus.wdata  = 32'hFFFFFFFF; bus.wstrb = 4'hF;
      bus.arvalid = 1'b1; bus.araddr = 8'h04; bus.arprot = 3'h0;
      bus.bready  = 1'b0; bus.rready = 1'b0;
      areset = 1'b1;
      model_reset();

      // Reset with every valid asserted
      for (int c = 0; c < 3; c++) begin
         tick();
         check("rst_awready", bus.awready, 0);
         check("rst_wready", bus.wready, 0);
         check("rst_arready", bus.arready, 0);
         check("rst_bvalid", bus.bvalid, 0);
         check("rst_rvalid", bus.rvalid, 0);
         check("rst_regs_out", regs_out, 0);
         check("rst_wr_pulse", wr_pulse, 0);
      end
      bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
      areset = 1'b0;
      tick();
      check("post_rst_awready", bus.awready, 1);
      check("post_rst_wready", bus.wready, 1);
      check("post_rst_arready", bus.arready, 1);
      check("post_rst_bvalid", bus.bvalid, 0);

      // A held AW must be discarded by reset
      bus.awvalid = 1'b1; bus.awaddr = 8'h18;
      tick();
      bus.awvalid = 1'b0;
      check("aw_only_no_b", bus.bvalid, 0);
      check("aw_hold_awready", bus.awready, 0);
      areset = 1'b1;
      tick();
      areset = 1'b0;
      bus.wvalid = 1'b1; bus.wdata = 32'hA5A5A5A5; bus.wstrb = 4'hF;
      tick();
      bus.wvalid = 1'b0;
      for (int c = 0; c < 2; c++) begin
         check("dropped_aw_no_b", bus.bvalid, 0);
         check("w_hold_wready", bus.wready, 0);
         check("dropped_aw_awready", bus.awready, 1);
         tick();
      end
      bus.awvalid = 1'b1; bus.awaddr = 8'h1C;
      tick();
      bus.awvalid = 1'b0;
      check("late_aw_bvalid", bus.bvalid, 1);
      check("late_aw_pulse", wr_pulse, 16'h0080);
      er = model_write(8'h1C, 32'hA5A5A5A5, 4'hF);
      check("late_aw_regs", regs_out, model_flat());
      bus.bready = 1'b1; tick(); bus.bready = 1'b0;
      check("late_aw_bclear", bus.bvalid, 0);

      // Vector table
      foreach (tbl[i]) begin
         if (tbl[i].is_wr) begin
            axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, i % 3, (i * 2) % 3, 0,
                      tbl[i].resp, tbl[i].pulse);
            er = model_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
            if (tbl[i].resp == 2'b00)
               check("vec_reg", regs_out[(int'(tbl[i].addr) / 4) * 32 +: 32], tbl[i].exp);
            check("vec_regs_all", regs_out, model_flat());
         end else begin
            axi_read(tbl[i].addr, i % 2, 0, tbl[i].exp, tbl[i].resp);
         end
      end

      // W leads AW by four cycles
      bus.wvalid = 1'b1; bus.wdata = 32'h11223344; bus.wstrb = 4'hF;
      check("skew_wready_first", bus.wready, 1);
      tick();
      bus.wvalid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         check("skew_wready_wait", bus.wready, 0);
         check("skew_no_b", bus.bvalid, 0);
         if (c == 3) begin
            bus.awvalid = 1'b1; bus.awaddr = 8'h10;
         end
         tick();
      end
      bus.awvalid = 1'b0;
      check("skew_bvalid", bus.bvalid, 1);
      check("skew_bresp", bus.bresp, 2'b00);
      check("skew_pulse", wr_pulse, 16'h0010);
      check("skew_reg4", regs_out[4*32 +: 32], 32'h11223344);
      er = model_write(8'h10, 32'h11223344, 4'hF);
      bus.bready = 1'b1; tick(); bus.bready = 1'b0;

      // Response backpressure on both channels
      axi_write(8'h14, 32'h0BADF00D, 4'hF, 0, 0, 5, 2'b00, 16'h0020);
      er = model_write(8'h14, 32'h0BADF00D, 4'hF);
      axi_write(8'hC4, 32'hDEADBEEF, 4'hF, 1, 0, 5, 2'b10, 16'h0000);
      axi_read(8'h14, 0, 5, 32'h0BADF00D, 2'b00);
      axi_read(8'hC4, 0, 5, 32'h0, 2'b10);

      // Read captured on the same edge as a write commit to the same register
      bus.awvalid = 1'b1; bus.awaddr = 8'h04;
      bus.wvalid  = 1'b1; bus.wdata  = 32'h12345678; bus.wstrb = 4'hF;
      bus.arvalid = 1'b1; bus.araddr = 8'h04;
      tick();
      bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
      check("coll_bvalid", bus.bvalid, 1);
      check("coll_rvalid", bus.rvalid, 1);
      check("coll_old_rdata", bus.rdata, 32'hDEADBEEF);
      check("coll_reg1", regs_out[1*32 +: 32], 32'h12345678);
      check("coll_pulse", wr_pulse, 16'h0002);
      er = model_write(8'h04, 32'h12345678, 4'hF);
      bus.bready = 1'b1; bus.rready = 1'b1;
      tick();
      bus.bready = 1'b0; bus.rready = 1'b0;
      check("coll_bclear", bus.bvalid, 0);
      check("coll_rclear", bus.rvalid, 0);
      axi_read(8'h04, 0, 0, 32'h12345678, 2'b00);

      // Random traffic against the model
      for (int it = 0; it < 80; it++) begin
         ra = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 63));
         if ($urandom_range(0, 1) == 1) begin
            rd = $urandom;
            rs = 4'($urandom);
            axi_write(ra, rd, rs, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                      (int'(ra) / 4 < 16) ? 2'b00 : 2'b10, model_pulse(ra));
            er = model_write(ra, rd, rs);
            check("rand_regs", regs_out, model_flat());
         end else begin
            axi_read(ra, $urandom_range(0, 2), $urandom_range(0, 2), model_rdata(ra),
                     (int'(ra) / 4 < 16) ? 2'b00 : 2'b10);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/axi4_lite_reg_slave.md
Name: axi4_lite_reg_slave

Overview:
Synthesizable AXI4-Lite slave register bank. It sits directly downstream of axi4_lite_master_bfm on an axi4_lite_if and consumes its write and read transactions. It is the first real DUT to replace axi4_lite_slave_bfm in the bench. Register contents are also exported flat for use by surrounding logic.

Parameters:
DATA_BYTES, 4, data bus width in bytes; also the register width.
ADDR_BYTES, 1, address bus width in bytes.
NUM_REGS, 16, number of registers; must satisfy 1 <= NUM_REGS <= 2^(ADDR_BYTES*8)/DATA_BYTES.

Ports:
aclk  in  1  single clock; all logic is on the rising edge.
areset  in  1  synchronous, active-high reset.
awvalid  in  1  write address valid.
awready  out  1  write address ready.
awaddr  in  ADDR_BYTES*8  write byte address.
awprot  in  3  ignored.
wvalid  in  1  write data valid.
wready  out  1  write data ready.
wdata  in  DATA_BYTES*8  write data.
wstrb  in  DATA_BYTES  byte enables.
bvalid  out  1  write response valid.
bready  in  1  write response ready.
bresp  out  2  write response code.
arvalid  in  1  read address valid.
arready  out  1  read address ready.
araddr  in  ADDR_BYTES*8  read byte address.
arprot  in  3  ignored.
rvalid  out  1  read data valid.
rready  in  1  read data ready.
rdata  out  DATA_BYTES*8  read data.
rresp  out  2  read response code.
regs_out  out  NUM_REGS*DATA_BYTES*8  flat register contents; reg i occupies bits [i*DATA_BYTES*8 +: DATA_BYTES*8].
wr_pulse  out  NUM_REGS  one-cycle strobe, bit i set when reg i is written.

Behaviour:
- Reset (areset=1 at a clock edge): all registers 0; bvalid, rvalid, wr_pulse all 0; bresp, rresp, rdata all 0; both FSMs go to IDLE. awready, wready and arready are forced to 0 while areset is high. Any in-flight transaction is dropped without a response.
- Address decode: index = addr >> log2(DATA_BYTES). The low log2(DATA_BYTES) address bits are ignored. index < NUM_REGS gives OKAY (2'b00); otherwise SLVERR (2'b10).
- Write FSM has two states, W_IDLE and W_RESP. Internal aw_hold and w_hold flags capture AW and W independently, in either order or in the same cycle.
- In W_IDLE: awready = !aw_hold; wready = !w_hold.
- have_aw = aw_hold | (awvalid & awready); have_w = w_hold | (wvalid & wready).
- At an edge in W_IDLE where have_aw and have_w are both true:
  - Commit the write, using live or held addr/data/strb as applicable.
  - Each byte k with wstrb[k]=1 is updated. Bytes with wstrb[k]=0 are unchanged.
  - wr_pulse[index] is 1 for the next cycle only, and is set even if wstrb is all zeros.
  - Out-of-range writes modify nothing and pulse nothing.
  - Set bvalid=1 and bresp to the decode result, clear both hold flags, and go to W_RESP.
  - Latency: bvalid is seen 1 cycle after the final AW/W handshake.
- In W_RESP: awready=wready=0. bvalid and bresp stay stable until bvalid&bready. At that edge bvalid goes to 0 and the FSM returns to W_IDLE. Back-to-back bursts are therefore 1 handshake per 2 cycles minimum.
- Read FSM has two states, R_IDLE and R_DATA.
- In R_IDLE: arready=1. On arvalid&arready, rdata takes reg[index] (0 if out of range), rresp takes the decode result, rvalid goes to 1, and the FSM goes to R_DATA.
- In R_DATA: arready=0. rdata and rresp are held until rvalid&rready, then rvalid goes to 0 and the FSM returns to R_IDLE.
- Read and write paths are fully independent. If a read is captured at the same edge as a write commit to the same register, the read returns the pre-write value.
- regs_out is the registered contents, updated at the commit edge.
- Holding a valid with no ready is legal; the slave never drops a captured beat except on reset.

Test Plan:
1. Reset: hold areset 3 cycles with awvalid/wvalid/arvalid all 1 -> all readys 0, bvalid=rvalid=0, regs_out all 0.
2. Write then read: AW and W together, addr 0x04, data 0xDEADBEEF, wstrb 0xF, bready=1 -> bvalid 1 cycle later with bresp=00, wr_pulse[1] for 1 cycle, regs_out reg1 = 0xDEADBEEF. Then read 0x04 -> rdata=0xDEADBEEF, rresp=00.
3. Skewed channels: W at 0x08 (data 0x11223344) handshakes 4 cycles before AW -> wready=0 while waiting; no bvalid until the cycle after the AW handshake; reg2 = 0x11223344.
4. Byte strobes: reg2=0x11223344, then write 0xAABBCCDD with wstrb 0x5 -> reg2 = 0x11BB33DD.
5. Out of range: write 0xDEADBEEF to 0xC4 -> bresp=10, no register or wr_pulse change. Read 0xC4 -> rdata=0, rresp=10.
6. Backpressure and concurrency:
   - bready=0 for 5 cycles: bvalid/bresp stable, awready=wready=0 throughout.
   - rready=0 for 5 cycles: rdata stable, arready=0 throughout.
   - Read of 0x04 captured at the same edge as a write 0x12345678 to 0x04 commits -> read returns the old value 0xDEADBEEF.
